// File: rtl/cache_pkg.sv
// Shared cache geometry and state encoding.
// Used by the instruction cache and the bus arbiter.
package cache_pkg;

    localparam int LINE_BYTES     = 64;
    localparam int LINE_BITS      = 512;
    localparam int WORD_BITS      = 64;
    localparam int OFFSET_BITS    = 6;
    localparam int WORDS_PER_LINE = LINE_BITS / WORD_BITS;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        RESP
    } icache_state_t;

    function automatic logic [WORD_BITS-1:0] line_word(
        input logic [LINE_BITS-1:0] line,
        input logic [2:0]           sel
    );
        return line[WORD_BITS*int'(sel) +: WORD_BITS];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped icache.
// One combinational read port, one write port, bulk invalidate.
module icache_array
    import cache_pkg::*;
#(
    parameter int SETS     = 64,
    parameter int IDX_BITS = $clog2(SETS),
    parameter int TAG_BITS = 64 - OFFSET_BITS - IDX_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_clr,
    input  logic [IDX_BITS-1:0]  rd_idx,
    output logic                 rd_valid,
    output logic [TAG_BITS-1:0]  rd_tag,
    output logic [LINE_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [LINE_BITS-1:0] wr_data
);

    logic [SETS-1:0]      valid_q;
    logic [TAG_BITS-1:0]  tag_q  [SETS];
    logic [LINE_BITS-1:0] data_q [SETS];

    // Only the valid bits are reset; tags and data are don't-care when invalid.
    always_ff @(posedge clk) begin
        if (reset || flush_clr) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache.
// Hits answer after one cycle; misses fetch a whole 64 B line.
module icache_dm
    import cache_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_BYTES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [63:0]          fetch_addr,
    output logic                 fetch_valid,
    output logic [63:0]          fetch_data,
    input  logic                 flush,
    output logic                 irequest,
    output logic [63:0]          iaddr,
    input  logic [LINE_BITS-1:0] idata,
    input  logic                 idone
);

    localparam int IDX_BITS = $clog2(SETS);
    localparam int TAG_BITS = 64 - OFFSET_BITS - IDX_BITS;

    if (LINE_BYTES != cache_pkg::LINE_BYTES) begin : g_bad_line
        $fatal(1, "icache_dm: LINE_BYTES must be 64");
    end

    if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
        $fatal(1, "icache_dm: SETS must be a power of two >= 2");
    end

    icache_state_t        state;
    logic                 flush_pending;
    logic [IDX_BITS-1:0]  idx;
    logic [TAG_BITS-1:0]  tag;
    logic [2:0]           word_sel;
    logic                 rd_valid;
    logic [TAG_BITS-1:0]  rd_tag;
    logic [LINE_BITS-1:0] rd_data;
    logic                 hit;
    logic                 lookup;
    logic                 flush_clr;
    logic                 fill;
    logic                 unused_low;

    assign idx        = fetch_addr[OFFSET_BITS +: IDX_BITS];
    assign tag        = fetch_addr[63 -: TAG_BITS];
    assign word_sel   = fetch_addr[5:3];
    assign unused_low = ^fetch_addr[2:0];

    assign hit = rd_valid && (rd_tag == tag);

    // A flush seen in IDLE (new or deferred) takes the cycle from lookup.
    assign flush_clr = (state == IDLE) && (flush || flush_pending);
    assign lookup    = (state == IDLE) && fetch_req && !flush_clr;
    assign fill      = (state == MISS) && idone;

    icache_array #(
        .SETS(SETS)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .flush_clr(flush_clr),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill),
        .wr_idx   (iaddr[OFFSET_BITS +: IDX_BITS]),
        .wr_tag   (iaddr[63 -: TAG_BITS]),
        .wr_data  (idata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            flush_pending <= 1'b0;
            fetch_valid   <= 1'b0;
            fetch_data    <= '0;
            irequest      <= 1'b0;
            iaddr         <= '0;
        end else begin
            fetch_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    flush_pending <= 1'b0;
                    if (lookup) begin
                        if (hit) begin
                            fetch_data  <= line_word(rd_data, word_sel);
                            fetch_valid <= 1'b1;
                            state       <= RESP;
                        end else begin
                            irequest <= 1'b1;
                            iaddr    <= {fetch_addr[63:OFFSET_BITS],
                                         {OFFSET_BITS{1'b0}}};
                            state    <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (flush) flush_pending <= 1'b1;
                    if (idone) begin
                        fetch_data  <= line_word(idata, word_sel);
                        fetch_valid <= 1'b1;
                        irequest    <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (flush) flush_pending <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Randomised self-checking bench for icache_dm against a line-level model.
// Memory content is a fixed function of the line address.
module tb_icache_dm;

    localparam int SETS = 64;
    localparam int IB   = $clog2(SETS);

    logic         clk = 1'b0;
    logic         reset;
    logic         fetch_req;
    logic [63:0]  fetch_addr;
    logic         fetch_valid;
    logic [63:0]  fetch_data;
    logic         flush;
    logic         irequest;
    logic [63:0]  iaddr;
    logic [511:0] idata;
    logic         idone;

    int checks = 0;
    int errors = 0;
    bit req_active = 1'b0;

    bit          mv    [SETS];
    logic [63:0] mline [SETS];

    always #5 clk = ~clk;

    icache_dm #(.SETS(SETS), .LINE_BYTES(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .flush      (flush),
        .irequest   (irequest),
        .iaddr      (iaddr),
        .idata      (idata),
        .idone      (idone)
    );

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return {a[63:6], 6'b0};
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        return int'(a[6 +: IB]);
    endfunction

    function automatic logic [63:0] mem_word(input logic [63:0] line,
                                             input int k);
        if (line == 64'h1000) return 64'hA0 + 64'(k);
        return (line * 64'h9E3779B97F4A7C15) ^ (64'(k) << 40)
               ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [511:0] mem_line(input logic [63:0] line);
        logic [511:0] v;
        for (int k = 0; k < 8; k++) v[64*k +: 64] = mem_word(line, k);
        return v;
    endfunction

    function automatic bit model_hit(input logic [63:0] a);
        return mv[idx_of(a)] && (mline[idx_of(a)] == line_of(a));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
    endtask

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Every-cycle output comparison against the model's memory image.
    always @(negedge clk) begin
        if (!reset) begin
            if (fetch_valid) begin
                check(req_active, "spurious_valid", 64'(req_active), 64'd1);
                if (req_active)
                    check(fetch_data == mem_word(line_of(fetch_addr),
                                                 int'(fetch_addr[5:3])),
                          "fetch_data", fetch_data,
                          mem_word(line_of(fetch_addr),
                                   int'(fetch_addr[5:3])));
            end
            if (irequest)
                check(req_active && iaddr == line_of(fetch_addr),
                      "iaddr", iaddr, line_of(fetch_addr));
        end
    end

    logic        q_req;
    logic        q_valid;
    logic [63:0] q_addr;

    always @(posedge clk) begin
        if (!reset && fetch_req && q_req && !q_valid)
            check(fetch_addr == q_addr, "addr_stable", fetch_addr, q_addr);
        q_req   <= fetch_req;
        q_valid <= fetch_valid;
        q_addr  <= fetch_addr;
    end

    // flush_at: -1 none, 0 with the request, n>0 at cycle n of the request.
    task automatic fetch(input logic [63:0] a, input int lat,
                         input int flush_at, output bit missed,
                         output logic [63:0] data,
                         output logic [63:0] req_addr);
        bit pred_miss;
        bit late_flush;
        bit got;
        int r;
        int c;
        int exp_r;
        r = -1;
        c = 0;
        got = 1'b0;
        late_flush = 1'b0;
        data = '0;
        req_addr = '0;
        @(posedge clk); #1;
        if (flush_at == 0) begin
            model_clear();
            flush = 1'b1;
        end
        pred_miss = !model_hit(a);
        fetch_addr = a;
        fetch_req = 1'b1;
        req_active = 1'b1;
        while (!got && c < 64) begin
            c++;
            @(posedge clk); #1;
            flush = (flush_at > 0 && c == flush_at);
            if (flush) late_flush = 1'b1;
            idone = (r > 0 && c == r + lat);
            idata = idone ? mem_line(line_of(a)) : 512'(0);
            @(negedge clk);
            if (irequest && r < 0) begin
                r = c;
                req_addr = iaddr;
            end
            if (fetch_valid) begin
                got = 1'b1;
                data = fetch_data;
            end
        end
        missed = (r > 0);
        check(got, "timeout", 64'(got), 64'd1);
        check(missed == pred_miss, "hit_miss", 64'(missed), 64'(pred_miss));
        if (got && missed) begin
            exp_r = (flush_at == 0) ? 2 : 1;
            check(r == exp_r, "miss_issue", 64'(r), 64'(exp_r));
            check(c == r + lat + 1, "miss_latency", 64'(c),
                  64'(r + lat + 1));
            check(!irequest, "irequest_clear", 64'(irequest), 64'd0);
        end else if (got) begin
            check(c == 1, "hit_latency", 64'(c), 64'd1);
        end
        if (got && pred_miss) begin
            mv[idx_of(a)] = 1'b1;
            mline[idx_of(a)] = line_of(a);
        end
        if (late_flush) model_clear();
        @(posedge clk); #1;
        fetch_req = 1'b0;
        req_active = 1'b0;
        flush = 1'b0;
        idone = 1'b0;
    endtask

    task automatic reset_mid_miss();
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        fetch_addr = 64'h1000;
        fetch_req = 1'b1;
        req_active = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = irequest;
        end
        check(seen, "rm_issue", 64'(seen), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        fetch_req = 1'b0;
        req_active = 1'b0;
        model_clear();
        @(negedge clk);
        check(!irequest, "rm_irequest_drop", 64'(irequest), 64'd0);
        @(posedge clk); #1;
        idone = 1'b1;
        idata = mem_line(64'h1000);
        @(posedge clk); #1;
        idone = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check(!fetch_valid, "rm_no_valid", 64'(fetch_valid), 64'd0);
        end
    endtask

    task automatic spurious_idone();
        @(posedge clk); #1;
        idone = 1'b1;
        idata = {16{$urandom}};
        @(posedge clk); #1;
        idone = 1'b0;
    endtask

    initial begin
        bit          m;
        logic [63:0] d;
        logic [63:0] ra;
        logic [63:0] a;
        int          sel;
        int          fa;
        reset = 1'b1;
        fetch_req = 1'b0;
        fetch_addr = '0;
        flush = 1'b0;
        idone = 1'b0;
        idata = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check(!fetch_valid, "rst_valid", 64'(fetch_valid), 64'd0);
        check(fetch_data == 0, "rst_data", fetch_data, 64'd0);
        check(!irequest, "rst_irequest", 64'(irequest), 64'd0);
        check(iaddr == 0, "rst_iaddr", iaddr, 64'd0);

        fetch(64'h1008, 5, -1, m, d, ra);
        check(m, "cold_miss", 64'(m), 64'd1);
        check(ra == 64'h1000, "cold_iaddr", ra, 64'h1000);
        check(d == 64'hA1, "cold_data", d, 64'hA1);

        fetch(64'h1038, 5, -1, m, d, ra);
        check(!m, "hit", 64'(m), 64'd0);
        check(d == 64'hA7, "hit_data", d, 64'hA7);

        fetch(64'h2000, 3, -1, m, d, ra);
        check(m, "conflict_miss", 64'(m), 64'd1);
        check(ra == 64'h2000, "conflict_iaddr", ra, 64'h2000);
        fetch(64'h1000, 3, -1, m, d, ra);
        check(m, "conflict_refetch", 64'(m), 64'd1);
        check(d == 64'hA0, "refetch_data", d, 64'hA0);

        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        model_clear();
        fetch(64'h1000, 2, -1, m, d, ra);
        check(m, "flush_idle_miss", 64'(m), 64'd1);

        fetch(64'h2008, 4, 2, m, d, ra);
        check(m, "flush_in_miss", 64'(m), 64'd1);
        fetch(64'h2008, 2, -1, m, d, ra);
        check(m, "flush_in_miss_refetch", 64'(m), 64'd1);

        fetch(64'h2010, 2, 0, m, d, ra);
        check(m, "flush_with_req", 64'(m), 64'd1);

        reset_mid_miss();
        fetch(64'h1000, 2, -1, m, d, ra);
        check(m, "after_reset_miss", 64'(m), 64'd1);

        spurious_idone();
        fetch(64'h1000, 2, -1, m, d, ra);
        check(!m, "spurious_ignored", 64'(m), 64'd0);
        check(d == 64'hA0, "spurious_data", d, 64'hA0);

        for (int n = 0; n < 300; n++) begin
            a = (64'($urandom_range(0, 3)) << 12)
              | (64'($urandom_range(0, 7)) << 6)
              | 64'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a[63] = 1'b1;
            sel = $urandom_range(0, 9);
            fa = (sel == 0) ? 0 : (sel < 3 ? $urandom_range(1, 6) : -1);
            fetch(a, $urandom_range(1, 6), fa, m, d, ra);
            if ($urandom_range(0, 7) == 0) spurious_idone();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
